param_updown_counter: RTL and testbench
=======================================

// Module: param_updown_counter
// PURPOSE
//   Parametrised up/down counter with programmable modulo limit, synchronous clear/load,
//   wrap or saturate mode, terminal-count pulse and sticky overflow flag.
//   Next-generation general counter for timers, event counting and address stepping.
//   Single clock domain; feeds control FSMs and status registers.
// PARAMETERS
//   WIDTH     8  counter width in bits (>=2)
//   RESET_VAL 0  count value on reset (must fit in WIDTH bits)
//   SATURATE  0  0 = wrap at limits, 1 = hold at limits
// PORTS
//   clk       in   1      clock, all state updates on rising edge
//   rst       in   1      asynchronous, active-high reset
//   clear     in   1      synchronous clear to 0 (highest priority)
//   load      in   1      synchronous load of load_val
//   load_val  in   WIDTH  value captured when load=1
//   enable    in   1      step enable
//   up_dn     in   1      1 = count up, 0 = count down
//   max_val   in   WIDTH  upper limit; count range is 0..max_val
//   ovf_clr   in   1      clears sticky ovf
//   count     out  WIDTH  current count (registered)
//   tc        out  1      terminal-count pulse (registered, one cycle per event)
//   ovf       out  1      sticky: set on any wrap/saturation event
// BEHAVIOUR
// - Reset (rst=1, async): count=RESET_VAL, tc=0, ovf=0; held while rst high.
// - Priority per edge: clear > load > enable step > hold.
// - clear: count<=0, tc<=0; no event. load: count<=load_val (not clamped), tc<=0.
// - enable=0 (and no clear/load): count holds, tc<=0.
// - Step up (enable=1, up_dn=1):
//     count<max_val: count<=count+1, tc<=0.
//     count>=max_val (boundary event): SATURATE=0 -> count<=0; SATURATE=1 -> count<=max_val.
// - Step down (enable=1, up_dn=0):
//     count>max_val: count<=max_val (boundary event; any mode).
//     0<count<=max_val: count<=count-1, tc<=0.
//     count==0 (boundary event): SATURATE=0 -> count<=max_val; SATURATE=1 -> count<=0.
// - Boundary event: tc<=1 for exactly the cycle carrying the new count; ovf<=1.
//   Saturate mode: tc pulses on every enabled step attempted at the limit.
// - ovf: set by event, cleared by ovf_clr; event and ovf_clr same edge -> ovf=1 (set wins).
// - Latency: one cycle from input edge to count/tc; no combinational input->output paths.
// - max_val=0: up step always wraps/holds at 0 with tc=1 each enabled cycle.
// - max_val changed mid-count: takes effect next edge; rules above apply to count>max_val.
// - Arithmetic modulo 2^WIDTH internally; count never leaves 0..max(max_val, last load_val).
// - rst mid-operation overrides everything immediately; pending events lost.
// TESTING (WIDTH=8 unless stated)
// 1. count=8'h37 running up, assert rst mid-cycle -> count=8'h00, tc=0, ovf=0 before next edge.
// 2. max_val=9, up from 0, enable=1 -> 1..9, then 0 with tc=1 that cycle only; ovf=1.
// 3. max_val=9, count=0, up_dn=0 -> count=9, tc=1; next edge 8, tc=0.
// 4. SATURATE=1, max_val=9, count=9, up 3 cycles -> count stays 9, tc=1 each cycle, ovf=1.
// 5. clear=load=enable=1, load_val=8'hC8 -> count=0; then load 8'hC8, max_val=9, up -> count=0, tc=1.
// 6. ovf=1, ovf_clr=1 with wrap event same edge -> ovf stays 1; next edge ovf_clr only -> ovf=0.

Source files
------------

// File: rtl/param_updown_counter.sv
// Up/down counter with a programmable modulo limit, synchronous clear/load, wrap or saturate
// mode, a registered terminal-count pulse and a sticky overflow flag.
module param_updown_counter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned RESET_VAL = 0,
   parameter bit          SATURATE  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             enable,
   input  logic             up_dn,
   input  logic [WIDTH-1:0] max_val,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] ResetCount = WIDTH'(RESET_VAL);

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             bound_evt;

   always_comb begin
      count_d   = count_q;
      bound_evt = 1'b0;
      if (clear) begin
         count_d = '0;
      end else if (load) begin
         count_d = load_val;
      end else if (enable) begin
         if (up_dn) begin
            if (count_q < max_val) begin
               count_d = count_q + 1'b1;
            end else begin
               bound_evt = 1'b1;
               count_d   = SATURATE ? max_val : '0;
            end
         end else begin
            // A count left above the limit by a load or a lowered max_val snaps to the limit.
            if (count_q > max_val) begin
               bound_evt = 1'b1;
               count_d   = max_val;
            end else if (count_q != '0) begin
               count_d = count_q - 1'b1;
            end else begin
               bound_evt = 1'b1;
               count_d   = SATURATE ? '0 : max_val;
            end
         end
      end
      tc_d  = bound_evt;
      // Set wins over a simultaneous clear request.
      ovf_d = bound_evt | (ovf_q & ~ovf_clr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= ResetCount;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count = count_q;
   assign tc    = tc_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed table-driven bench for param_updown_counter: a wrapping instance with RESET_VAL=0
// and a saturating instance with RESET_VAL=5, both fed the same inputs.
module tb_param_updown_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       clear, load, enable, up_dn, ovf_clr;
   logic [7:0] load_val, max_val;
   logic [7:0] count_w, count_s;
   logic       tc_w, tc_s, ovf_w, ovf_s;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   param_updown_counter #(.WIDTH(8), .RESET_VAL(0), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
      .enable(enable), .up_dn(up_dn), .max_val(max_val), .ovf_clr(ovf_clr),
      .count(count_w), .tc(tc_w), .ovf(ovf_w)
   );

   param_updown_counter #(.WIDTH(8), .RESET_VAL(5), .SATURATE(1'b1)) u_sat (
      .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
      .enable(enable), .up_dn(up_dn), .max_val(max_val), .ovf_clr(ovf_clr),
      .count(count_s), .tc(tc_s), .ovf(ovf_s)
   );

   typedef struct {
      logic       clr;
      logic       ld;
      logic [7:0] ld_val;
      logic       en;
      logic       up;
      logic [7:0] mx;
      logic       oc;
      logic [7:0] e_cnt;
      logic       e_tc;
      logic       e_ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic clr, input logic ld, input logic [7:0] ld_val,
                      input logic en, input logic up, input logic [7:0] mx, input logic oc,
                      input logic [7:0] e_cnt, input logic e_tc, input logic e_ovf);
      vec_t v;
      v.clr = clr; v.ld = ld; v.ld_val = ld_val; v.en = en; v.up = up; v.mx = mx;
      v.oc = oc; v.e_cnt = e_cnt; v.e_tc = e_tc; v.e_ovf = e_ovf;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic clr, input logic ld, input logic [7:0] ld_val,
                        input logic en, input logic up, input logic [7:0] mx, input logic oc);
      @(negedge clk);
      clear = clr; load = ld; load_val = ld_val; enable = en; up_dn = up;
      max_val = mx; ovf_clr = oc;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Wrap-mode vectors: clr ld ld_val en up mx oc -> count tc ovf
      for (int i = 1; i <= 9; i++) add(0, 0, 8'h00, 1, 1, 8'd9, 0, 8'(i), 0, 0);
      add(0, 0, 8'h00, 1, 1, 8'd9, 0, 8'd0, 1, 1);    // wrap 9 -> 0
      add(0, 0, 8'h00, 0, 1, 8'd9, 0, 8'd0, 0, 1);    // hold, tc drops
      add(0, 0, 8'h00, 1, 0, 8'd9, 0, 8'd9, 1, 1);    // down from 0 wraps to max
      add(0, 0, 8'h00, 1, 0, 8'd9, 0, 8'd8, 0, 1);
      add(0, 0, 8'h00, 0, 0, 8'd9, 1, 8'd8, 0, 0);    // ovf_clr alone
      add(1, 1, 8'hC8, 1, 1, 8'd9, 0, 8'd0, 0, 0);    // clear beats load and enable
      add(0, 1, 8'hC8, 1, 1, 8'd9, 0, 8'hC8, 0, 0);   // load beats enable, not clamped
      add(0, 0, 8'h00, 1, 1, 8'd9, 0, 8'd0, 1, 1);    // up above max wraps
      add(0, 1, 8'hC8, 0, 0, 8'd9, 0, 8'hC8, 0, 1);
      add(0, 0, 8'h00, 1, 0, 8'd9, 0, 8'd9, 1, 1);    // down above max snaps to max
      add(0, 0, 8'h00, 1, 1, 8'd9, 1, 8'd0, 1, 1);    // event beats ovf_clr
      add(0, 0, 8'h00, 0, 1, 8'd9, 1, 8'd0, 0, 0);
      add(0, 0, 8'h00, 1, 1, 8'd0, 0, 8'd0, 1, 1);    // max_val=0 up
      add(0, 0, 8'h00, 1, 1, 8'd0, 0, 8'd0, 1, 1);    // tc again each enabled cycle
      add(0, 0, 8'h00, 1, 0, 8'd0, 0, 8'd0, 1, 1);    // max_val=0 down
      add(0, 1, 8'hFF, 0, 1, 8'hFF, 1, 8'hFF, 0, 0);
      add(0, 0, 8'h00, 1, 1, 8'hFF, 0, 8'h00, 1, 1);  // full-width wrap

      clear = 0; load = 0; load_val = 0; enable = 0; up_dn = 1; max_val = 8'd9; ovf_clr = 0;
      rst = 1'b1;
      #12;
      chk("reset count", 32'(count_w), 32'h00);
      chk("reset tc", 32'(tc_w), 32'h0);
      chk("reset ovf", 32'(ovf_w), 32'h0);
      chk("reset count sat RESET_VAL", 32'(count_s), 32'h05);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].clr, vecs[i].ld, vecs[i].ld_val, vecs[i].en, vecs[i].up, vecs[i].mx,
               vecs[i].oc);
         chk($sformatf("vec%0d count", i), 32'(count_w), 32'(vecs[i].e_cnt));
         chk($sformatf("vec%0d tc", i), 32'(tc_w), 32'(vecs[i].e_tc));
         chk($sformatf("vec%0d ovf", i), 32'(ovf_w), 32'(vecs[i].e_ovf));
      end

      // Async reset mid-cycle while counting up with ovf set
      drive(0, 1, 8'h37, 0, 1, 8'hFF, 0);
      chk("pre-rst load", 32'(count_w), 32'h37);
      drive(0, 0, 8'h00, 1, 1, 8'hFF, 0);
      chk("pre-rst step", 32'(count_w), 32'h38);
      chk("pre-rst ovf", 32'(ovf_w), 32'h1);
      rst = 1'b1;
      #1;
      chk("async rst count", 32'(count_w), 32'h00);
      chk("async rst tc", 32'(tc_w), 32'h0);
      chk("async rst ovf", 32'(ovf_w), 32'h0);
      @(posedge clk);
      #1;
      chk("rst held count", 32'(count_w), 32'h00);
      @(negedge clk);
      rst = 1'b0;

      // Saturating instance: hold at max with tc every attempted step
      drive(0, 1, 8'd9, 0, 1, 8'd9, 0);
      chk("sat load", 32'(count_s), 32'd9);
      chk("sat ovf before", 32'(ovf_s), 32'h0);
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 8'h00, 1, 1, 8'd9, 0);
         chk($sformatf("sat up%0d count", k), 32'(count_s), 32'd9);
         chk($sformatf("sat up%0d tc", k), 32'(tc_s), 32'h1);
         chk($sformatf("sat up%0d ovf", k), 32'(ovf_s), 32'h1);
      end
      drive(0, 0, 8'h00, 1, 0, 8'd9, 0);
      chk("sat down count", 32'(count_s), 32'd8);
      chk("sat down tc", 32'(tc_s), 32'h0);
      drive(1, 0, 8'h00, 0, 0, 8'd9, 1);
      chk("sat clear count", 32'(count_s), 32'd0);
      chk("sat clear ovf", 32'(ovf_s), 32'h0);
      drive(0, 0, 8'h00, 1, 0, 8'd9, 0);
      chk("sat floor count", 32'(count_s), 32'd0);
      chk("sat floor tc", 32'(tc_s), 32'h1);
      drive(0, 1, 8'hC8, 0, 0, 8'd9, 0);
      drive(0, 0, 8'h00, 1, 1, 8'd9, 0);
      chk("sat up above max", 32'(count_s), 32'd9);
      chk("sat up above max tc", 32'(tc_s), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
